// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, oversampling phases and frame constants
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    localparam int OVS       = 16;
    localparam int PH_W      = $clog2(OVS);
    localparam int DATA_BITS = 8;

    localparam logic [PH_W-1:0] PH_S0  = PH_W'(7);
    localparam logic [PH_W-1:0] PH_S1  = PH_W'(8);
    localparam logic [PH_W-1:0] PH_S2  = PH_W'(9);
    localparam logic [PH_W-1:0] PH_END = PH_W'(OVS - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with show-ahead read port: rdata always presents the entry at the
// read pointer, so the head is visible without a read strobe.
module uart_rx_fifo #(
    parameter int AW = 3,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam int DEPTH = 2 ** AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote, framing-error
// detection and a show-ahead receive FIFO drained by the CPU.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int DIV = 163,
    parameter int AW  = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          rx,
    input  logic          rd_en,
    input  logic          clr_err,
    output logic [7:0]    data,
    output logic          valid,
    output logic [AW:0]   count,
    output logic          frame_err,
    output logic          overrun
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    uart_state_t          state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        cnt_freq;
    logic [PH_W-1:0]      ph;
    logic [2:0]           bit_idx;
    logic [1:0]           samples;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 push_req;
    logic                 tick;
    logic                 bit_val;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign tick    = (state != IDLE) && (cnt_freq == '0);
    assign bit_val = majority3(samples[0], samples[1], rx_s);
    assign valid   = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Returning to IDLE at mid-stop-bit lets a following start edge be caught without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_freq  <= CNT_MAX;
            ph        <= '0;
            bit_idx   <= '0;
            samples   <= '0;
            shift_reg <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_req <= 1'b0;
            if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (state == IDLE) begin
                cnt_freq <= CNT_MAX;
                ph       <= '0;
                if (!rx_s) begin
                    state <= START;
                end
            end else begin
                cnt_freq <= (cnt_freq == '0) ? CNT_MAX : cnt_freq - 1'b1;
                if (state == BREAK) begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end else if (tick) begin
                    ph <= ph + 1'b1;
                    if (ph == PH_S0) samples[0] <= rx_s;
                    if (ph == PH_S1) samples[1] <= rx_s;
                    case (state)
                        START: begin
                            if (ph == PH_S2 && bit_val) begin
                                state <= IDLE;
                            end else if (ph == PH_END) begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end
                        DATA: begin
                            if (ph == PH_S2) begin
                                shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
                            end
                            if (ph == PH_END) begin
                                if (bit_idx == 3'd7) begin
                                    state <= STOP;
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                end
                            end
                        end
                        STOP: begin
                            if (ph == PH_S2) begin
                                if (bit_val) begin
                                    push_req <= 1'b1;
                                    state    <= IDLE;
                                end else begin
                                    frame_err <= 1'b1;
                                    state     <= BREAK;
                                end
                            end
                        end
                        default: state <= state;
                    endcase
                end
            end
        end
    end

    // A set in the same cycle as clr_err wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            if (clr_err) begin
                overrun <= 1'b0;
            end
            if (push_req && fifo_full && !rd_en) begin
                overrun <= 1'b1;
            end
        end
    end

    uart_rx_fifo #(
        .AW (AW),
        .W  (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .pop   (rd_en),
        .wdata (shift_reg),
        .rdata (data),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench for uart_rx_buffered with DIV=2 (32 clocks per bit); a byte
// scoreboard tracks what the FIFO should hold and pops are compared against it.
module tb_uart_rx_buffered;

    localparam int DIV   = 2;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;
    localparam int BIT   = 32;

    logic        clk;
    logic        rst_n;
    logic        rx;
    logic        rd_en;
    logic        clr_err;
    logic [7:0]  data;
    logic        valid;
    logic [AW:0] count;
    logic        frame_err;
    logic        overrun;

    logic [7:0]  exp_q[$];
    logic        exp_ovr;
    int          checks;
    int          errors;

    uart_rx_buffered #(
        .DIV (DIV),
        .AW  (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rd_en     (rd_en),
        .clr_err   (clr_err),
        .data      (data),
        .valid     (valid),
        .count     (count),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one frame starting at a negedge; pop_at pulses rd_en on that cycle,
    // abort_at asserts reset on that cycle and ends the frame early.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit, input int pop_at, input int abort_at);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10 * BIT; c++) begin
            if (c == abort_at) begin
                rst_n = 1'b0;
                rx    = 1'b1;
                rd_en = 1'b0;
                return;
            end
            rx    = frame[c / BIT];
            rd_en = (c == pop_at);
            @(negedge clk);
        end
        rd_en = 1'b0;
        rx    = 1'b1;
    endtask

    task automatic sendGood(input logic [7:0] b);
        applyStimulus(b, 1'b1, -1, -1);
        if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic popCheck(input string tag);
        logic [7:0] e;
        checkOutput({tag, " model nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        checkOutput(tag, 32'(data), 32'(e));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic pulseClr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_ovr = 1'b0;
        rst_n   = 1'b0;
        rx      = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset valid", 32'(valid), 32'd0);
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset overrun", 32'(overrun), 32'd0);
        checkOutput("reset data", 32'(data), 32'h00);
        rst_n = 1'b1;
        idle(10);

        $display("[TB] back-to-back 0x55, 0xA3");
        sendGood(8'h55);
        sendGood(8'hA3);
        idle(5);
        checkOutput("b2b valid", 32'(valid), 32'd1);
        checkOutput("b2b count", 32'(count), 32'd2);
        popCheck("b2b pop0");
        popCheck("b2b pop1");
        checkOutput("b2b drained", 32'(valid), 32'd0);

        $display("[TB] start glitch");
        rx = 1'b0;
        repeat (10) @(negedge clk);
        idle(80);
        checkOutput("glitch count", 32'(count), 32'd0);
        checkOutput("glitch frame_err", 32'(frame_err), 32'd0);

        $display("[TB] framing error");
        applyStimulus(8'h3C, 1'b0, -1, -1);
        idle(20);
        checkOutput("ferr set", 32'(frame_err), 32'd1);
        checkOutput("ferr count", 32'(count), 32'd0);
        pulseClr();
        checkOutput("ferr cleared", 32'(frame_err), 32'd0);
        idle(10);
        sendGood(8'h3C);
        idle(5);
        checkOutput("after ferr count", 32'(count), 32'd1);
        checkOutput("after ferr frame_err", 32'(frame_err), 32'd0);
        popCheck("after ferr pop");

        $display("[TB] overflow with nine frames");
        for (int i = 1; i <= 9; i++) sendGood(8'(i));
        idle(5);
        checkOutput("ovf count", 32'(count), 32'd8);
        checkOutput("ovf overrun", 32'(overrun), 32'(exp_ovr));
        for (int i = 0; i < DEPTH; i++) popCheck("ovf pop");
        checkOutput("ovf drained count", 32'(count), 32'd0);
        pulseClr();
        exp_ovr = 1'b0;
        checkOutput("ovf cleared", 32'(overrun), 32'd0);

        $display("[TB] push into full FIFO with simultaneous pop");
        for (int i = 0; i < DEPTH; i++) sendGood(8'h10 + 8'(i));
        idle(3);
        checkOutput("full count", 32'(count), 32'd8);
        checkOutput("full head", 32'(data), 32'(exp_q[0]));
        // Push lands 311 cycles after the start edge is driven (sync + 9.5 bit periods).
        applyStimulus(8'h77, 1'b1, 311, -1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h77);
        idle(3);
        checkOutput("pop+push count", 32'(count), 32'd8);
        checkOutput("pop+push overrun", 32'(overrun), 32'd0);
        for (int i = 0; i < DEPTH; i++) popCheck("pop+push drain");

        $display("[TB] reset mid-frame");
        sendGood(8'h5A);
        pulseClr();
        applyStimulus(8'hE1, 1'b1, -1, 5 * BIT + 10);
        exp_q.delete();
        repeat (3) @(negedge clk);
        checkOutput("midreset valid", 32'(valid), 32'd0);
        checkOutput("midreset count", 32'(count), 32'd0);
        checkOutput("midreset data", 32'(data), 32'h00);
        rst_n = 1'b1;
        idle(10);
        sendGood(8'hE1);
        idle(5);
        checkOutput("post reset count", 32'(count), 32'd1);
        popCheck("post reset pop");
        checkOutput("post reset frame_err", 32'(frame_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
